// File: rtl/l2_sram_ctrl.sv
// L2 memory controller: req/gnt port to tc_sram with multi-cycle read latency,
// in-order responses and credit-based grant throttling against rready_i.
module l2_sram_ctrl #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned NumWords      = 1024,
  parameter int unsigned SramLatency   = 1,
  parameter int unsigned RspDepth      = 2,
  localparam int unsigned StrbWidth     = DataWidth / 8,
  localparam int unsigned SramAddrWidth = $clog2(NumWords)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic [AddrWidth-1:0]     addr_i,
  input  logic                     we_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic [StrbWidth-1:0]     strb_i,
  output logic                     rvalid_o,
  output logic [DataWidth-1:0]     rdata_o,
  input  logic                     rready_i,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [SramAddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [StrbWidth-1:0]     sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i,
  output logic                     busy_o
);

  localparam int unsigned ByteOffset = $clog2(StrbWidth);
  localparam int unsigned CntWidth   = $clog2(RspDepth + 1);
  localparam int unsigned PtrWidth   = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned MemSlots   = 2 ** PtrWidth;

  if (SramLatency < 1) begin : g_bad_latency
    $error("l2_sram_ctrl: SramLatency must be at least 1");
  end
  if (RspDepth < 1) begin : g_bad_depth
    $error("l2_sram_ctrl: RspDepth must be at least 1");
  end

  logic [CntWidth-1:0]    r_cnt;
  logic [CntWidth-1:0]    r_fifo_cnt;
  logic [PtrWidth-1:0]    r_rd_ptr;
  logic [PtrWidth-1:0]    r_wr_ptr;
  logic [DataWidth-1:0]   r_fifo_mem [MemSlots];
  logic [SramLatency-1:0] r_pipe_vld;
  logic [SramLatency-1:0] r_pipe_we;

  logic                   w_gnt;
  logic                   w_arrive;
  logic [DataWidth-1:0]   w_arrive_data;
  logic                   w_fifo_empty;
  logic                   w_fifo_full;
  logic                   w_rvalid;
  logic                   w_pop;
  logic                   w_fifo_pop;
  logic                   w_push;
  logic [SramLatency-1:0] w_pipe_vld_nxt;
  logic [SramLatency-1:0] w_pipe_we_nxt;
  logic                   w_unused_addr;

  // Grant only while a response slot is guaranteed; a pop frees its credit next cycle.
  assign w_gnt = req_i & (r_cnt < CntWidth'(RspDepth)) & ~rst_i;
  assign gnt_o = w_gnt;

  assign sram_req_o   = w_gnt;
  assign sram_we_o    = we_i;
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = strb_i;
  assign sram_addr_o  = addr_i[ByteOffset +: SramAddrWidth];

  // Upper address bits are dropped on purpose so addresses wrap modulo NumWords.
  assign w_unused_addr = ^addr_i;

  if (SramLatency > 1) begin : g_pipe_multi
    assign w_pipe_vld_nxt = {r_pipe_vld[SramLatency-2:0], w_gnt};
    assign w_pipe_we_nxt  = {r_pipe_we[SramLatency-2:0], we_i};
  end else begin : g_pipe_single
    assign w_pipe_vld_nxt = w_gnt;
    assign w_pipe_we_nxt  = we_i;
  end

  assign w_arrive      = r_pipe_vld[SramLatency-1];
  assign w_arrive_data = r_pipe_we[SramLatency-1] ? '0 : sram_rdata_i;

  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_fifo_full  = (r_fifo_cnt == CntWidth'(RspDepth));

  // Fall-through: an arriving word is presented directly when nothing older is queued.
  assign w_rvalid   = ~rst_i & (~w_fifo_empty | w_arrive);
  assign w_pop      = w_rvalid & rready_i;
  assign w_fifo_pop = w_pop & ~w_fifo_empty;
  assign w_push     = ~rst_i & w_arrive & ~(w_fifo_empty & rready_i);

  assign rvalid_o = w_rvalid;
  assign rdata_o  = !w_rvalid   ? '0 :
                    w_fifo_empty ? w_arrive_data : r_fifo_mem[r_rd_ptr];
  assign busy_o   = ~rst_i & (r_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_pipe_vld <= '0;
      r_pipe_we  <= '0;
      r_fifo_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      case ({w_gnt, w_pop})
        2'b10:   r_cnt <= r_cnt + CntWidth'(1);
        2'b01:   r_cnt <= r_cnt - CntWidth'(1);
        default: r_cnt <= r_cnt;
      endcase

      r_pipe_vld <= w_pipe_vld_nxt;
      r_pipe_we  <= w_pipe_we_nxt;

      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PtrWidth'(RspDepth - 1)) ? '0 : r_wr_ptr + PtrWidth'(1);
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrWidth'(RspDepth - 1)) ? '0 : r_rd_ptr + PtrWidth'(1);
      end

      case ({w_push, w_fifo_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CntWidth'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CntWidth'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Response storage carries no reset; occupancy is tracked by r_fifo_cnt.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_arrive_data;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && w_fifo_full && !w_fifo_pop));

endmodule

// File: tb/tb_l2_sram_ctrl.sv
// Directed bench for l2_sram_ctrl: instance A (latency 1, depth 2) and
// instance B (latency 2, depth 3), each with a behavioural SRAM model.
module tb_l2_sram_ctrl;

  localparam int unsigned DW  = 512;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned SAW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {SW{b}};
  endfunction

  // ---------------- instance A ----------------
  logic           a_rst, a_req, a_gnt, a_we, a_rvalid, a_rready, a_busy;
  logic [AW-1:0]  a_addr;
  logic [DW-1:0]  a_wdata, a_rdata, a_swdata, a_srdata;
  logic [SW-1:0]  a_strb, a_sbe;
  logic           a_sreq, a_swe;
  logic [SAW-1:0] a_saddr;
  logic [DW-1:0]  mem_a [1024];

  l2_sram_ctrl #(.SramLatency(1), .RspDepth(2)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
    .we_i(a_we), .wdata_i(a_wdata), .strb_i(a_strb), .rvalid_o(a_rvalid),
    .rdata_o(a_rdata), .rready_i(a_rready), .sram_req_o(a_sreq), .sram_we_o(a_swe),
    .sram_addr_o(a_saddr), .sram_wdata_o(a_swdata), .sram_be_o(a_sbe),
    .sram_rdata_i(a_srdata), .busy_o(a_busy)
  );

  always @(posedge clk) begin
    if (a_sreq) begin
      if (a_swe) begin
        for (int i = 0; i < SW; i++)
          if (a_sbe[i]) mem_a[a_saddr][i*8 +: 8] = a_swdata[i*8 +: 8];
      end else begin
        a_srdata <= mem_a[a_saddr];
      end
    end
  end

  // ---------------- instance B ----------------
  logic           b_rst, b_req, b_gnt, b_we, b_rvalid, b_rready, b_busy;
  logic [AW-1:0]  b_addr;
  logic [DW-1:0]  b_wdata, b_rdata, b_swdata, b_srdata, b_rd1;
  logic [SW-1:0]  b_strb, b_sbe;
  logic           b_sreq, b_swe;
  logic [SAW-1:0] b_saddr;
  logic [DW-1:0]  mem_b [1024];

  l2_sram_ctrl #(.SramLatency(2), .RspDepth(3)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr),
    .we_i(b_we), .wdata_i(b_wdata), .strb_i(b_strb), .rvalid_o(b_rvalid),
    .rdata_o(b_rdata), .rready_i(b_rready), .sram_req_o(b_sreq), .sram_we_o(b_swe),
    .sram_addr_o(b_saddr), .sram_wdata_o(b_swdata), .sram_be_o(b_sbe),
    .sram_rdata_i(b_srdata), .busy_o(b_busy)
  );

  always @(posedge clk) begin
    if (b_sreq) begin
      if (b_swe) begin
        for (int i = 0; i < SW; i++)
          if (b_sbe[i]) mem_b[b_saddr][i*8 +: 8] = b_swdata[i*8 +: 8];
      end else begin
        b_rd1 <= mem_b[b_saddr];
      end
    end
    b_srdata <= b_rd1;
  end

  // One cycle: drive at the falling edge, then settle before sampling.
  task automatic cyc_a(input logic rst, input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [SW-1:0] strb, input logic rready);
    @(negedge clk);
    a_rst = rst; a_req = req; a_we = we; a_addr = addr;
    a_wdata = wdata; a_strb = strb; a_rready = rready;
    #1;
  endtask

  task automatic cyc_b(input logic rst, input logic req, input logic [AW-1:0] addr,
                       input logic rready);
    @(negedge clk);
    b_rst = rst; b_req = req; b_addr = addr; b_rready = rready;
    #1;
  endtask

  logic [DW-1:0] exp_w7;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[1] = fill(8'h11);
    mem_a[2] = fill(8'h22);
    mem_a[3] = fill(8'h33);
    mem_a[5] = fill(8'hA5);
    mem_a[7] = fill(8'h77);
    for (int i = 0; i < 16; i++) mem_b[i] = {16{32'hB000_0000 + 32'(i)}};

    a_rst = 1'b1; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_strb = '0;
    a_rready = 1'b0; a_srdata = '0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_strb = '0;
    b_rready = 1'b0; b_srdata = '0; b_rd1 = '0;
    repeat (2) @(negedge clk);

    // reset state with a request pending
    cyc_a(1, 1, 0, 32'h140, '0, '0, 1);
    check("rst_gnt", a_gnt, 0);
    check("rst_sram_req", a_sreq, 0);
    check("rst_rvalid", a_rvalid, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_busy", a_busy, 0);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("post_rst_rvalid", a_rvalid, 0);
    check("post_rst_busy", a_busy, 0);
    check("post_rst_sram_req", a_sreq, 0);

    // single read of word 5
    cyc_a(0, 1, 0, 32'h140, '0, '0, 1);
    check("rd_gnt", a_gnt, 1);
    check("rd_sram_req", a_sreq, 1);
    check("rd_sram_addr", a_saddr, 5);
    check("rd_sram_we", a_swe, 0);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("rd_rvalid", a_rvalid, 1);
    check("rd_rdata", a_rdata, fill(8'hA5));
    check("rd_busy", a_busy, 1);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("rd_idle_rvalid", a_rvalid, 0);
    check("rd_idle_busy", a_busy, 0);

    // partial write to word 7, then read it back
    cyc_a(0, 1, 1, 32'h1C0, DW'(16'h1234), SW'(2'b11), 1);
    check("wr_gnt", a_gnt, 1);
    check("wr_sram_we", a_swe, 1);
    check("wr_sram_be", a_sbe, 3);
    check("wr_sram_addr", a_saddr, 7);
    cyc_a(0, 1, 0, 32'h1C0, '0, '0, 1);
    check("wr_rsp_rvalid", a_rvalid, 1);
    check("wr_rsp_rdata", a_rdata, 0);
    check("wr_rd_gnt", a_gnt, 1);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    exp_w7 = fill(8'h77);
    exp_w7[15:0] = 16'h1234;
    check("wr_rd_rvalid", a_rvalid, 1);
    check("wr_rd_rdata", a_rdata, exp_w7);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("wr_idle_rvalid", a_rvalid, 0);

    // back-pressure: credits run out at depth 2
    cyc_a(0, 1, 0, 32'h040, '0, '0, 0);
    check("bp_gnt0", a_gnt, 1);
    cyc_a(0, 1, 0, 32'h080, '0, '0, 0);
    check("bp_gnt1", a_gnt, 1);
    check("bp_rvalid1", a_rvalid, 1);
    check("bp_rdata1", a_rdata, fill(8'h11));
    cyc_a(0, 1, 0, 32'h0C0, '0, '0, 0);
    check("bp_gnt2", a_gnt, 0);
    check("bp_busy2", a_busy, 1);
    check("bp_rdata2", a_rdata, fill(8'h11));
    cyc_a(0, 1, 0, 32'h0C0, '0, '0, 0);
    check("bp_gnt3", a_gnt, 0);
    check("bp_rdata3", a_rdata, fill(8'h11));
    cyc_a(0, 1, 0, 32'h0C0, '0, '0, 1);
    check("bp_pop_gnt", a_gnt, 0);
    check("bp_pop_rvalid", a_rvalid, 1);
    check("bp_pop_rdata", a_rdata, fill(8'h11));
    cyc_a(0, 1, 0, 32'h0C0, '0, '0, 0);
    check("bp_regnt", a_gnt, 1);
    check("bp_rdata5", a_rdata, fill(8'h22));
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("bp_rvalid6", a_rvalid, 1);
    check("bp_rdata6", a_rdata, fill(8'h22));
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("bp_rvalid7", a_rvalid, 1);
    check("bp_rdata7", a_rdata, fill(8'h33));
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("bp_rvalid8", a_rvalid, 0);
    check("bp_busy8", a_busy, 0);

    // address wrap modulo NumWords
    cyc_a(0, 1, 0, 32'h0001_0040, '0, '0, 1);
    check("wrap_gnt", a_gnt, 1);
    check("wrap_sram_addr", a_saddr, 1);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("wrap_rdata", a_rdata, fill(8'h11));

    // reset with two responses outstanding
    cyc_a(0, 1, 0, 32'h040, '0, '0, 0);
    cyc_a(0, 1, 0, 32'h080, '0, '0, 0);
    cyc_a(0, 0, 0, '0, '0, '0, 0);
    check("mr_busy_pre", a_busy, 1);
    check("mr_rvalid_pre", a_rvalid, 1);
    cyc_a(1, 1, 0, 32'h040, '0, '0, 0);
    check("mr_rst_rvalid", a_rvalid, 0);
    check("mr_rst_gnt", a_gnt, 0);
    check("mr_rst_busy", a_busy, 0);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("mr_post_rvalid", a_rvalid, 0);
    check("mr_post_busy", a_busy, 0);
    cyc_a(0, 1, 0, 32'h0C0, '0, '0, 1);
    check("mr_rd_gnt", a_gnt, 1);
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("mr_rd_rvalid", a_rvalid, 1);
    check("mr_rd_rdata", a_rdata, fill(8'h33));
    cyc_a(0, 0, 0, '0, '0, '0, 1);
    check("mr_rd_done", a_rvalid, 0);

    // streaming on B: 16 back-to-back reads, latency 2
    cyc_b(0, 0, '0, 1);
    check("b_post_rst_rvalid", b_rvalid, 0);
    for (int k = 0; k < 19; k++) begin
      cyc_b(0, k < 16, (k < 16) ? AW'(k) << 6 : '0, 1);
      check($sformatf("b_gnt%0d", k), b_gnt, DW'(k < 16));
      if (k >= 2 && k < 18) begin
        check($sformatf("b_rvalid%0d", k), b_rvalid, 1);
        check($sformatf("b_rdata%0d", k), b_rdata, {16{32'hB000_0000 + 32'(k - 2)}});
      end else begin
        check($sformatf("b_rvalid%0d", k), b_rvalid, 0);
      end
    end
    cyc_b(0, 0, '0, 1);
    check("b_busy_end", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_sram_ctrl.md
# l2_sram_ctrl

L2 memory controller between the L2 req/gnt memory port (driven by the AXI-to-memory bridge on the L2 slave of the system crossbar) and the L2 `tc_sram` macro.
- Supports SRAM read latencies greater than one cycle.
- Returns one in-order response per granted request.
- Applies response back-pressure (`rready_i`) through credit-based granting, so no response is ever dropped.
- Replaces the current "grant = request, rvalid = registered request" glue.

## Interface
- `AddrWidth`, 32: request byte-address width.
- `DataWidth`, 512: data width; `StrbWidth = DataWidth/8`.
- `NumWords`, 1024: SRAM depth; `SramAddrWidth = $clog2(NumWords)`.
- `SramLatency`, 1: cycles from `sram_req_o` to valid `sram_rdata_i`; must be ≥ 1.
- `RspDepth`, 2: maximum outstanding responses (in flight plus buffered); must be ≥ 1. Full throughput requires `RspDepth` ≥ `SramLatency`+1.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. One clock; reset is synchronous and active-high.
- `req_i`, in, 1: request valid.
- `gnt_o`, out, 1: request accepted this cycle.
- `addr_i`, in, `AddrWidth`: byte address.
- `we_i`, in, 1: write enable.
- `wdata_i`, in, `DataWidth`: write data.
- `strb_i`, in, `StrbWidth`: byte enables.
- `rvalid_o`, out, 1: response valid.
- `rdata_o`, out, `DataWidth`: response data.
- `rready_i`, in, 1: response accepted.
- `sram_req_o`, out, 1: SRAM access strobe.
- `sram_we_o`, out, 1: SRAM write enable.
- `sram_addr_o`, out, `SramAddrWidth`: SRAM word address.
- `sram_wdata_o`, out, `DataWidth`: SRAM write data.
- `sram_be_o`, out, `StrbWidth`: SRAM byte enables.
- `sram_rdata_i`, in, `DataWidth`: SRAM read data.
- `busy_o`, out, 1: any response outstanding.

## Operation
- **Credit counter** `cnt` (0..`RspDepth`) tracks granted-but-not-popped responses.
  - Increments on grant and decrements on pop (`rvalid_o & rready_i`).
  - On simultaneous grant and pop, `cnt` is unchanged.
- **Grant:** `gnt_o = req_i & (cnt < RspDepth) & ~rst_i`.
  - A pop in the current cycle does not free a credit until the next cycle; there is no `rready_i`→`gnt_o` combinational path.
- **SRAM issue:** `sram_req_o = gnt_o`; `sram_we_o = we_i`; `sram_wdata_o = wdata_i`; `sram_be_o = strb_i`.
  - `sram_addr_o = addr_i[ByteOffset +: SramAddrWidth]`, with `ByteOffset = $clog2(StrbWidth)`.
  - Upper address bits are ignored, so addresses wrap modulo `NumWords`.
- **Latency pipe:** a `SramLatency`-deep shift register of {valid, is_write} per grant.
  - At the pipe output, the response word is `sram_rdata_i` for reads and all-zero for writes.
  - Every granted request, read or write, produces exactly one response.
- **Response FIFO:** depth `RspDepth`, in order, with fall-through when empty.
  - A word arriving at the pipe output while the FIFO is empty drives `rvalid_o`/`rdata_o` combinationally in that cycle.
  - If the word is not popped, it is stored.
  - Credits guarantee the FIFO never overflows. An assertion must flag a push into a full FIFO.
- `busy_o = (cnt != 0)`.
- **Reset:** clears `cnt`, the latency pipe and the FIFO.
  - Responses in flight or buffered are discarded; SRAM data returning after reset is ignored.
  - SRAM writes already issued are not undone.

## Timing
- Output values while `rst_i`=1 and in the first cycle after reset: `gnt_o`=0 (while reset is asserted), `sram_req_o`=0, `rvalid_o`=0, `rdata_o`=0, `busy_o`=0.
- **Latency:** grant in cycle T gives `rvalid_o` in cycle T+`SramLatency` when the FIFO is empty and no older response is pending.
- **Throughput:** one grant per cycle with `rready_i` held at 1 when `RspDepth` ≥ `SramLatency`+1. Otherwise grants stall once `cnt` reaches `RspDepth`.
- **Back-pressure:**
  - `rvalid_o` and `rdata_o` stay stable until popped.
  - When `rready_i` is low, `gnt_o` drops once `cnt` reaches `RspDepth` and reasserts the cycle after the first pop.
- `req_i` may be deasserted or changed without waiting for a grant; the block never latches an ungranted request.
- **Reset asserted mid-burst:** `rvalid_o` falls in the same cycle, and no stale response appears after release.

## Test plan
- **Single read:** `SramLatency`=1, SRAM preloaded with word 5 = 0xA5…A5. Read `addr_i`=0x140 → `gnt_o`=1 in cycle T, `sram_addr_o`=5, `rvalid_o`=1 with `rdata_o`=0xA5…A5 at T+1.
- **Write then read:** write 0x1234 with `strb_i`=0x3 at word 7, then read word 7 → write response has `rdata_o`=0; read returns low 16 bits 0x1234 and other bytes unchanged.
- **Streaming:** `SramLatency`=2, `RspDepth`=3, `rready_i`=1, 16 back-to-back reads → 16 consecutive grants, responses in order at T+2…T+17, `busy_o` low afterwards.
- **Back-pressure:** `RspDepth`=2, `rready_i`=0, `req_i` held high → exactly 2 grants, then `gnt_o`=0. Raising `rready_i` for one cycle → one pop, `gnt_o`=1 the next cycle. No response lost or duplicated.
- **Address wrap:** `NumWords`=1024, read `addr_i`=0x0001_0040 → `sram_addr_o`=1.
- **Reset mid-operation:** assert `rst_i` with 2 responses outstanding → `rvalid_o`=0 and `busy_o`=0 after reset. The first post-reset read returns only its own data.
